dac_update_scheduler: RTL and testbench

- Sequences the AD5725 DAC interface block. Holds a 12-bit shadow setpoint for each of the 4 DAC channels.
- Issues the DAC reset command after system reset, then pushes every changed channel to the DAC one at a time using round-robin order.
- Sits between host-side register writes and the DAC interface's cs/op/addr/data_in/rdy handshake, and detects a hung DAC with a timeout.

---
 rtl/dac_update_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_dac_update_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_update_scheduler.sv
// DAC update scheduler: keeps per-channel shadow setpoints, resets the DAC
// after system reset, then pushes changed channels one at a time in
// round-robin order over the cs/op/addr/data_in/rdy handshake.
module dac_update_scheduler #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_chan,
  input  logic [11:0]      wr_data,
  input  logic             err_clr,
  output logic             busy,
  output logic [3:0]       pending,
  output logic             err,
  output logic [CNT_W-1:0] update_count,
  output logic             dac_cs,
  output logic [3:0]       dac_op,
  output logic [7:0]       dac_addr,
  output logic [15:0]      dac_data_in,
  input  logic             dac_rdy
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  localparam logic [3:0] OpReset = 4'b0001;
  localparam logic [3:0] OpWrite = 4'b0010;

  typedef enum logic [1:0] {
    StRstPulse,
    StWaitLow,
    StWaitHigh,
    StIdle
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        pending_q, pending_d;
  logic [11:0]       shadow_q [4];
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              is_upd_q, is_upd_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic [3:0]        op_q, op_d;
  logic [7:0]        addr_q, addr_d;
  logic [15:0]       data_q, data_d;

  logic              sel_found;
  logic [1:0]        sel_ch;
  logic              timeout;
  logic [3:0]        pend_clr;
  logic [3:0]        pend_set;
  logic [3:0]        wr_set;

  // Round-robin pick: first pending channel after the last one served.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = rr_ptr_q;
    for (int i = 1; i <= 4; i++) begin
      if (!sel_found && pending_q[2'(rr_ptr_q + 2'(i))]) begin
        sel_found = 1'b1;
        sel_ch    = 2'(rr_ptr_q + 2'(i));
      end
    end
  end

  // Sequencer next state and registered DAC command outputs.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rr_ptr_d = rr_ptr_q;
    is_upd_d = is_upd_q;
    cnt_d    = cnt_q;
    cs_d     = 1'b0;
    op_d     = 4'b0000;
    addr_d   = addr_q;
    data_d   = data_q;
    pend_clr = 4'b0000;
    pend_set = 4'b0000;
    timeout  = 1'b0;

    unique case (state_q)
      StRstPulse: begin
        cs_d     = 1'b1;
        op_d     = OpReset;
        addr_d   = 8'h00;
        data_d   = 16'h0000;
        is_upd_d = 1'b0;
        timer_d  = '0;
        state_d  = StWaitLow;
      end
      StWaitLow: begin
        if (!dac_rdy) begin
          state_d = StWaitHigh;
          timer_d = '0;
        end else if (timer_q == TimerMax) begin
          timeout = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StWaitHigh: begin
        if (dac_rdy) begin
          state_d = StIdle;
          timer_d = '0;
          if (is_upd_q) cnt_d = cnt_q + CNT_W'(1);
        end else if (timer_q == TimerMax) begin
          timeout = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StIdle: begin
        if (sel_found) begin
          cs_d             = 1'b1;
          op_d             = OpWrite;
          addr_d           = {6'b0, sel_ch};
          data_d           = {4'b0, shadow_q[sel_ch]};
          pend_clr[sel_ch] = 1'b1;
          rr_ptr_d         = sel_ch;
          is_upd_d         = 1'b1;
          timer_d          = '0;
          state_d          = StWaitLow;
        end
      end
      default: state_d = StRstPulse;
    endcase

    // A hung DAC re-queues the in-flight channel and re-resets the DAC.
    if (timeout) begin
      state_d = StRstPulse;
      timer_d = '0;
      if (is_upd_q) pend_set[rr_ptr_q] = 1'b1;
    end
  end

  // Host writes set pending after any clear, so a write racing an issue wins.
  always_comb begin
    wr_set = 4'b0000;
    if (wr_en) wr_set[wr_chan] = 1'b1;
    pending_d = (pending_q & ~pend_clr) | pend_set | wr_set;
    err_d     = (err_q & ~err_clr) | timeout;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRstPulse;
      timer_q   <= '0;
      pending_q <= 4'b0000;
      rr_ptr_q  <= 2'd3;
      is_upd_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      cs_q      <= 1'b0;
      op_q      <= 4'b0000;
      addr_q    <= 8'h00;
      data_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      is_upd_q  <= is_upd_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // Shadow setpoints; the issue path samples the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) shadow_q[i] <= 12'h000;
    end else if (wr_en) begin
      shadow_q[wr_chan] <= wr_data;
    end
  end

  assign busy         = (state_q != StIdle);
  assign pending      = pending_q;
  assign err          = err_q;
  assign update_count = cnt_q;
  assign dac_cs       = cs_q;
  assign dac_op       = op_q;
  assign dac_addr     = addr_q;
  assign dac_data_in  = data_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler with a simple DAC handshake model.
module tb_dac_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_chan;
  logic [11:0] wr_data;
  logic        err_clr;
  logic        busy;
  logic [3:0]  pending;
  logic        err;
  logic [15:0] update_count;
  logic        dac_cs;
  logic [3:0]  dac_op;
  logic [7:0]  dac_addr;
  logic [15:0] dac_data_in;
  logic        dac_rdy = 1'b1;

  logic        stuck = 1'b0;
  int          rdy_cnt = 0;
  logic [27:0] cmd_log [$];
  logic [1:0]  rr_order [4] = '{2'd3, 2'd1, 2'd0, 2'd2};

  int n_vec = 0;
  int n_err = 0;

  localparam logic [27:0] CmdReset = {4'h1, 8'h00, 16'h0000};

  dac_update_scheduler #(
    .TIMEOUT(64),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_chan     (wr_chan),
    .wr_data     (wr_data),
    .err_clr     (err_clr),
    .busy        (busy),
    .pending     (pending),
    .err         (err),
    .update_count(update_count),
    .dac_cs      (dac_cs),
    .dac_op      (dac_op),
    .dac_addr    (dac_addr),
    .dac_data_in (dac_data_in),
    .dac_rdy     (dac_rdy)
  );

  always #5 clk = ~clk;

  // DAC model: rdy falls one cycle after cs, rises four cycles later; stuck holds rdy high.
  always @(posedge clk) begin
    if (stuck) begin
      dac_rdy <= 1'b1;
      rdy_cnt <= 0;
    end else if (dac_cs) begin
      dac_rdy <= 1'b0;
      rdy_cnt <= 4;
    end else if (rdy_cnt != 0) begin
      rdy_cnt <= rdy_cnt - 1;
      if (rdy_cnt == 1) dac_rdy <= 1'b1;
    end
  end

  // Record every command strobe.
  always @(negedge clk) begin
    if (dac_cs) cmd_log.push_back({dac_op, dac_addr, dac_data_in});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cs(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dac_cs && n < max);
    check_val("cs_seen", {31'b0, dac_cs}, 32'd1);
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max);
    check_val("idle_seen", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_count(input logic [15:0] target);
    for (int i = 0; i < 300; i++) begin
      if (update_count == target) break;
      @(negedge clk);
    end
    check_val("update_count", {16'b0, update_count}, {16'b0, target});
  endtask

  task automatic host_write(input logic [1:0] ch, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_chan = ch;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  function automatic logic [27:0] cmd_wr(input logic [1:0] ch, input logic [11:0] d);
    return {4'h2, 6'b0, ch, 4'h0, d};
  endfunction

  initial begin
    int n;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_chan = 2'd0;
    wr_data = 12'h000;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_cs", {31'b0, dac_cs}, 32'd0);
    check_val("rst_op", {28'b0, dac_op}, 32'd0);
    check_val("rst_addr", {24'b0, dac_addr}, 32'd0);
    check_val("rst_data", {16'b0, dac_data_in}, 32'd0);
    check_val("rst_pending", {28'b0, pending}, 32'd0);
    check_val("rst_err", {31'b0, err}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd1);

    // Init: one reset pulse, then idle after the handshake
    cmd_log.delete();
    rst = 1'b0;
    wait_cs(20, n);
    check_val("init_cs_lat", n, 32'd1);
    check_val("init_op", {28'b0, dac_op}, 32'h1);
    @(negedge clk);
    check_val("init_cs_1cyc", {31'b0, dac_cs}, 32'd0);
    wait_idle(20, n);
    check_val("init_idle_lat", n, 32'd5);
    check_val("init_count", {16'b0, update_count}, 32'd0);
    check_val("init_err", {31'b0, err}, 32'd0);
    check_val("init_ncmd", cmd_log.size(), 32'd1);

    // Single write: cs two cycles after the write
    host_write(2'd2, 12'hABC);
    check_val("sw_cs_early", {31'b0, dac_cs}, 32'd0);
    check_val("sw_pending", {28'b0, pending}, 32'h4);
    @(negedge clk);
    check_val("sw_cs", {31'b0, dac_cs}, 32'd1);
    check_val("sw_op", {28'b0, dac_op}, 32'h2);
    check_val("sw_addr", {24'b0, dac_addr}, 32'h02);
    check_val("sw_data", {16'b0, dac_data_in}, 32'h0ABC);
    @(negedge clk);
    check_val("sw_cs_1cyc", {31'b0, dac_cs}, 32'd0);
    wait_count(16'd1);
    check_val("sw_pending_done", {28'b0, pending}, 32'h0);

    // Round-robin from reset pointer; writes land during the reset handshake
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmd_log.delete();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_chan = rr_order[i];
      wr_data = 12'hD00 + 12'(rr_order[i]);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_count(16'd4);
    check_val("rr_ncmd", cmd_log.size(), 32'd5);
    check_val("rr_cmd0", {4'b0, cmd_log[0]}, {4'b0, CmdReset});
    for (int k = 0; k < 4; k++) begin
      check_val("rr_cmd", {4'b0, cmd_log[k+1]}, {4'b0, cmd_wr(2'(k), 12'hD00 + 12'(k))});
    end

    // Coalesce (ch1 written twice while ch0 in flight) and write racing issue
    cmd_log.delete();
    host_write(2'd0, 12'h0AA);
    wr_en = 1'b1; wr_chan = 2'd1; wr_data = 12'h111;
    @(negedge clk);
    wr_data = 12'h222;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (5) @(negedge clk);
    wr_en = 1'b1; wr_chan = 2'd1; wr_data = 12'h333;
    @(negedge clk);
    wr_en = 1'b0;
    check_val("race_cs", {31'b0, dac_cs}, 32'd1);
    check_val("race_addr", {24'b0, dac_addr}, 32'h01);
    check_val("race_data", {16'b0, dac_data_in}, 32'h0222);
    check_val("race_pending", {28'b0, pending}, 32'h2);
    wait_count(16'd7);
    check_val("co_ncmd", cmd_log.size(), 32'd3);
    check_val("co_cmd0", {4'b0, cmd_log[0]}, {4'b0, cmd_wr(2'd0, 12'h0AA)});
    check_val("co_cmd1", {4'b0, cmd_log[1]}, {4'b0, cmd_wr(2'd1, 12'h222)});
    check_val("co_cmd2", {4'b0, cmd_log[2]}, {4'b0, cmd_wr(2'd1, 12'h333)});

    // Timeout: rdy never drops; 64 cycles in WAIT_LOW then a reset pulse
    cmd_log.delete();
    stuck = 1'b1;
    host_write(2'd0, 12'h055);
    wait_cs(10, n);
    check_val("to_issue_data", {16'b0, dac_data_in}, 32'h0055);
    wait_cs(100, n);
    check_val("to_gap", n, 32'd65);
    check_val("to_op", {28'b0, dac_op}, 32'h1);
    check_val("to_err", {31'b0, err}, 32'd1);
    check_val("to_pending", {28'b0, pending}, 32'h1);
    stuck = 1'b0;
    wait_count(16'd8);
    check_val("to_err_sticky", {31'b0, err}, 32'd1);
    check_val("to_ncmd", cmd_log.size(), 32'd3);
    check_val("to_resend", {4'b0, cmd_log[2]}, {4'b0, cmd_wr(2'd0, 12'h055)});
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_val("err_clr", {31'b0, err}, 32'd0);

    // Reset during WAIT_HIGH of a ch3 update with ch1 also pending
    host_write(2'd3, 12'h7E7);
    wr_en = 1'b1; wr_chan = 2'd1; wr_data = 12'h1AB;
    @(negedge clk);
    wr_en = 1'b0;
    check_val("mid_cs", {31'b0, dac_cs}, 32'd1);
    check_val("mid_addr", {24'b0, dac_addr}, 32'h03);
    repeat (2) @(negedge clk);
    check_val("mid_pending", {28'b0, pending}, 32'h2);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_cs", {31'b0, dac_cs}, 32'd0);
    check_val("mid_rst_op", {28'b0, dac_op}, 32'd0);
    check_val("mid_rst_addr", {24'b0, dac_addr}, 32'd0);
    check_val("mid_rst_data", {16'b0, dac_data_in}, 32'd0);
    check_val("mid_rst_pending", {28'b0, pending}, 32'd0);
    check_val("mid_rst_count", {16'b0, update_count}, 32'd0);
    check_val("mid_rst_busy", {31'b0, busy}, 32'd1);
    repeat (6) @(negedge clk);
    cmd_log.delete();
    rst = 1'b0;
    wait_idle(30, n);
    check_val("mid_ncmd", cmd_log.size(), 32'd1);
    check_val("mid_cmd0", {4'b0, cmd_log[0]}, {4'b0, CmdReset});
    check_val("mid_pending_end", {28'b0, pending}, 32'd0);
    check_val("mid_count_end", {16'b0, update_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
